// File: rtl/mos6502s_status_reg.sv
// 6502 processor status register (N V - B D I Z C) with ALU/flag-op/PLP/interrupt update paths.
// Latency: flags and irq_mask update one cycle after the qualifying edge; push_data is combinational.
// Backpressure: none, since every input is a single-cycle strobe.
// Build option: MOS6502S_CMOS_DCLR_EN makes interrupt entry clear D (65C02). When it is undefined, D is kept (NMOS).
module mos6502s_status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [2:0] flag_op,
  input  logic       plp_load,
  input  logic [7:0] data_in,
  input  logic       irq_entry,
  input  logic       brk_push,
  input  logic       instr_done,
  output logic [7:0] p_out,
  output logic [7:0] push_data,
  output logic       c_out,
  output logic       d_out,
  output logic       irq_mask
);

  typedef enum logic [2:0] {
    FLAG_NONE = 3'd0,
    FLAG_CLC  = 3'd1,
    FLAG_SEC  = 3'd2,
    FLAG_CLI  = 3'd3,
    FLAG_SEI  = 3'd4,
    FLAG_CLD  = 3'd5,
    FLAG_SED  = 3'd6,
    FLAG_CLV  = 3'd7
  } flag_op_e;

  flag_op_e op;
  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
  logic irq_mask_q;

  // The unused bits are the B and constant-1 positions, which have no storage in P.
  logic unused_data_in;
  assign unused_data_in = ^data_in[5:4];

  assign op = flag_op_e'(flag_op);

  // Each later stage overwrites the earlier ones, so the lowest-priority source is applied first.
  always_comb begin
    n_nx = n_q;
    v_nx = v_q;
    d_nx = d_q;
    i_nx = i_q;
    z_nx = z_q;
    c_nx = c_q;

    if (upd_nz) begin
      n_nx = alu_n;
      z_nx = alu_z;
    end
    if (upd_c) c_nx = alu_c;
    if (upd_v) v_nx = alu_v;

    case (op)
      FLAG_CLC: c_nx = 1'b0;
      FLAG_SEC: c_nx = 1'b1;
      FLAG_CLI: i_nx = 1'b0;
      FLAG_SEI: i_nx = 1'b1;
      FLAG_CLD: d_nx = 1'b0;
      FLAG_SED: d_nx = 1'b1;
      FLAG_CLV: v_nx = 1'b0;
      default:  ;
    endcase

    if (irq_entry) begin
      i_nx = 1'b1;
`ifdef MOS6502S_CMOS_DCLR_EN
      d_nx = 1'b0;
`endif
    end

    if (plp_load) begin
      n_nx = data_in[7];
      v_nx = data_in[6];
      d_nx = data_in[3];
      i_nx = data_in[2];
      z_nx = data_in[1];
      c_nx = data_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      d_q        <= 1'b0;
      i_q        <= 1'b1;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      irq_mask_q <= 1'b1;
    end else begin
      n_q <= n_nx;
      v_q <= v_nx;
      d_q <= d_nx;
      i_q <= i_nx;
      z_q <= z_nx;
      c_q <= c_nx;
      // The mask samples the registered I, which gives the one-instruction delay on CLI/SEI/PLP.
      if (instr_done) irq_mask_q <= i_q;
    end
  end

  assign p_out     = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign push_data = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign c_out     = c_q;
  assign d_out     = d_q;
  assign irq_mask  = irq_mask_q;

endmodule

// File: tb/tb_mos6502s_status_reg.sv
// Directed-vector bench for mos6502s_status_reg with hand-computed expected values.
module tb_mos6502s_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic       upd_nz, upd_c, upd_v;
  logic [2:0] flag_op;
  logic       plp_load;
  logic [7:0] data_in;
  logic       irq_entry;
  logic       brk_push;
  logic       instr_done;
  logic [7:0] p_out;
  logic [7:0] push_data;
  logic       c_out, d_out, irq_mask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mos6502s_status_reg dut (
    .clk(clk), .rst(rst),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
    .flag_op(flag_op), .plp_load(plp_load), .data_in(data_in),
    .irq_entry(irq_entry), .brk_push(brk_push), .instr_done(instr_done),
    .p_out(p_out), .push_data(push_data),
    .c_out(c_out), .d_out(d_out), .irq_mask(irq_mask)
  );

  task automatic idle();
    rst = 1'b0; alu_n = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; flag_op = 3'd0;
    plp_load = 1'b0; data_in = 8'h00; irq_entry = 1'b0; brk_push = 1'b0; instr_done = 1'b0;
  endtask

  // Apply the current inputs for one edge, then return the inputs to idle and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step();
    n_vec++; if (p_out !== 8'h24) begin n_err++; $display("FAIL reset_p got %h exp 24", p_out); end
    n_vec++; if (irq_mask !== 1'b1) begin n_err++; $display("FAIL reset_mask got %b exp 1", irq_mask); end
    n_vec++; if (c_out !== 1'b0) begin n_err++; $display("FAIL reset_c got %b exp 0", c_out); end
    n_vec++; if (d_out !== 1'b0) begin n_err++; $display("FAIL reset_d got %b exp 0", d_out); end
    brk_push = 1'b1; #1;
    n_vec++; if (push_data !== 8'h34) begin n_err++; $display("FAIL reset_push_b1 got %h exp 34", push_data); end
    brk_push = 1'b0; #1;
    n_vec++; if (push_data !== 8'h24) begin n_err++; $display("FAIL reset_push_b0 got %h exp 24", push_data); end
  endtask

  task automatic test_alu_update();
    alu_n = 1'b1; alu_z = 1'b0; alu_c = 1'b1; alu_v = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; step();
    n_vec++; if (p_out !== 8'hA5) begin n_err++; $display("FAIL alu_nzc got %h exp A5", p_out); end
    n_vec++; if (c_out !== 1'b1) begin n_err++; $display("FAIL alu_c_out got %b exp 1", c_out); end
    alu_v = 1'b1; upd_v = 1'b1; step();
    n_vec++; if (p_out !== 8'hE5) begin n_err++; $display("FAIL alu_v got %h exp E5", p_out); end
    alu_n = 1'b0; alu_z = 1'b1; upd_nz = 1'b1; step();
    n_vec++; if (p_out !== 8'h67) begin n_err++; $display("FAIL alu_nz got %h exp 67", p_out); end
    step();
    n_vec++; if (p_out !== 8'h67) begin n_err++; $display("FAIL alu_hold got %h exp 67", p_out); end
  endtask

  task automatic test_flag_op();
    flag_op = 3'd1; upd_c = 1'b1; alu_c = 1'b1; step();
    n_vec++; if (p_out !== 8'h66 || c_out !== 1'b0) begin n_err++; $display("FAIL clc_vs_alu got %h/%b exp 66/0", p_out, c_out); end
    flag_op = 3'd6; upd_c = 1'b1; alu_c = 1'b1; step();
    n_vec++; if (p_out !== 8'h6F || d_out !== 1'b1) begin n_err++; $display("FAIL sed_plus_alu_c got %h/%b exp 6F/1", p_out, d_out); end
    flag_op = 3'd7; upd_v = 1'b1; alu_v = 1'b1; step();
    n_vec++; if (p_out !== 8'h2F) begin n_err++; $display("FAIL clv_vs_alu got %h exp 2F", p_out); end
    flag_op = 3'd5; step();
    n_vec++; if (p_out !== 8'h27 || d_out !== 1'b0) begin n_err++; $display("FAIL cld got %h/%b exp 27/0", p_out, d_out); end
    flag_op = 3'd1; step();
    flag_op = 3'd2; step();
    n_vec++; if (p_out !== 8'h27) begin n_err++; $display("FAIL clc_sec got %h exp 27", p_out); end
  endtask

  task automatic test_plp();
    plp_load = 1'b1; data_in = 8'hFF; irq_entry = 1'b1; flag_op = 3'd7; step();
    n_vec++; if (p_out !== 8'hEF) begin n_err++; $display("FAIL plp_ff got %h exp EF", p_out); end
    brk_push = 1'b0; #1;
    n_vec++; if (push_data !== 8'hEF) begin n_err++; $display("FAIL push_b0 got %h exp EF", push_data); end
    brk_push = 1'b1; #1;
    n_vec++; if (push_data !== 8'hFF) begin n_err++; $display("FAIL push_b1 got %h exp FF", push_data); end
    brk_push = 1'b0;
    plp_load = 1'b1; data_in = 8'h30; irq_entry = 1'b1; upd_nz = 1'b1; alu_n = 1'b1; step();
    n_vec++; if (p_out !== 8'h20) begin n_err++; $display("FAIL plp_30 got %h exp 20", p_out); end
  endtask

  task automatic test_irq_mask();
    rst = 1'b1; step();
    flag_op = 3'd3; step();
    n_vec++; if (p_out !== 8'h20 || irq_mask !== 1'b1) begin n_err++; $display("FAIL cli_latency got %h/%b exp 20/1", p_out, irq_mask); end
    instr_done = 1'b1; step();
    n_vec++; if (irq_mask !== 1'b0) begin n_err++; $display("FAIL cli_boundary got %b exp 0", irq_mask); end
    irq_entry = 1'b1; flag_op = 3'd3; step();
    n_vec++; if (p_out !== 8'h24 || irq_mask !== 1'b0) begin n_err++; $display("FAIL irq_over_cli got %h/%b exp 24/0", p_out, irq_mask); end
    instr_done = 1'b1; step();
    n_vec++; if (irq_mask !== 1'b1) begin n_err++; $display("FAIL irq_boundary got %b exp 1", irq_mask); end
    flag_op = 3'd3; instr_done = 1'b1; step();
    n_vec++; if (p_out !== 8'h20 || irq_mask !== 1'b1) begin n_err++; $display("FAIL same_cycle_pre got %h/%b exp 20/1", p_out, irq_mask); end
    instr_done = 1'b1; step();
    n_vec++; if (irq_mask !== 1'b0) begin n_err++; $display("FAIL same_cycle_next got %b exp 0", irq_mask); end
  endtask

  task automatic test_dclr();
    logic [7:0] exp_p;
`ifdef MOS6502S_CMOS_DCLR_EN
    exp_p = 8'h24;
`else
    exp_p = 8'h2C;
`endif
    flag_op = 3'd6; step();
    n_vec++; if (p_out !== 8'h28) begin n_err++; $display("FAIL sed_setup got %h exp 28", p_out); end
    irq_entry = 1'b1; step();
    n_vec++; if (p_out !== exp_p) begin n_err++; $display("FAIL irq_dclr got %h exp %h", p_out, exp_p); end
    plp_load = 1'b1; data_in = 8'h08; irq_entry = 1'b1; step();
    n_vec++; if (p_out !== 8'h28) begin n_err++; $display("FAIL plp_over_dclr got %h exp 28", p_out); end
  endtask

  task automatic test_reset_override();
    plp_load = 1'b1; data_in = 8'hFF; step();
    instr_done = 1'b1; step();
    rst = 1'b1; plp_load = 1'b1; data_in = 8'h00; instr_done = 1'b1;
    upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1; alu_n = 1'b1; alu_c = 1'b1; alu_v = 1'b1; flag_op = 3'd6;
    step();
    n_vec++; if (p_out !== 8'h24 || irq_mask !== 1'b1) begin n_err++; $display("FAIL rst_override got %h/%b exp 24/1", p_out, irq_mask); end
    step();
    n_vec++; if (p_out !== 8'h24 || c_out !== 1'b0 || d_out !== 1'b0) begin n_err++; $display("FAIL rst_no_residue got %h/%b/%b exp 24/0/0", p_out, c_out, d_out); end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_alu_update();
    test_flag_op();
    test_plp();
    test_irq_mask();
    test_dclr();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
